write_buffer_coalescing: RTL and testbench
==========================================

Name: write_buffer_coalescing

Overview:
Parametrised, coalescing write buffer between the cache write path and the main-memory arbiter.
- Accepts word writes with byte enables into a DEPTH-entry FIFO and drains them oldest-first to memory over a memen/memdone handshake.
- Merges a new write into a pending entry with the same word address, freeing slots and cutting memory traffic.
- Optionally forwards buffered bytes to a read lookup port, so reads see writes that have not yet reached memory.

Parameters:
DEPTH, 4, number of entries; power of two, >=2
ADR_W, 27, word-address width
DATA_W, 32, data width; multiple of 8; BE_W = DATA_W/8 is derived, not a parameter

Ports:
ph1  input  1  two-phase clock, phase 1; state advances once per cycle at rising ph1
ph2  input  1  two-phase clock, phase 2
reset  input  1  reset, asynchronous, active-low
adr  input  ADR_W  write word address
data  input  DATA_W  write data
byteen  input  BE_W  write byte enables
en  input  1  write request
done  output  1  write accepted this cycle when en=1 (combinational)
memadr  output  ADR_W  memory word address (registered)
memdata  output  DATA_W  memory write data (registered)
membyteen  output  BE_W  memory byte enables (registered)
memen  output  1  memory write request (registered)
memdone  input  1  memory completed current write
lkadr  input  ADR_W  lookup address
lkhit  output  1  lookup hit (combinational)
lkdata  output  DATA_W  forwarded data
lkbyteen  output  BE_W  forwarded byte valid mask
count  output  $clog2(DEPTH+1)  valid entries
empty  output  1  count==0
full  output  1  count==DEPTH

Behaviour:
- Storage: per entry, valid, adr, data, byteen. Circular head (oldest) and tail (next free) pointers, log2(DEPTH) bits, wrap modulo DEPTH.
- In-flight entry: the head entry while memen=1.
- Merge hit: en=1 and a valid, non-in-flight entry has adr equal to the input adr.
  - Invariant: at most one such entry exists.
- done = (byteen==0) | merge hit | ~full.
- Accept (en & done):
  - byteen==0: discard; no state change.
  - Merge hit: for each byte i with byteen[i]=1, entry.data byte i <= data byte i; entry.byteen |= byteen. count is unchanged.
  - Otherwise: write into tail, set valid, tail++, count++.
- The in-flight entry is never merged into; a same-address write allocates a new entry.
- Drain FSM, states IDLE and BUSY:
  - IDLE: if head valid, load memadr/memdata/membyteen from head, memen<=1, go to BUSY.
  - BUSY: when memdone=1, clear head valid, head++, count--. If the next entry is valid, load it and stay in BUSY (back-to-back, memen stays 1). Otherwise memen<=0, go to IDLE.
  - memdone is ignored in IDLE.
- Latency: a write accepted into an empty buffer at cycle N gives memen=1 at cycle N+1.
- Simultaneous accept and retire in the same cycle:
  - count nets to unchanged.
  - full is evaluated on pre-edge state, so done=0 when full, even if memdone=1 that cycle (no pass-through).
- Simultaneous merge into the entry that is being loaded at that edge (IDLE->BUSY): the merge wins. The registered memdata/membyteen load the merged value.
- Reset asserted, asynchronously:
  - All valid bits 0; head=tail=0; FSM to IDLE.
  - memen=0, memadr=0, memdata=0, membyteen=0; count=0, empty=1, full=0; done=1.
  - Pending writes are dropped, including the in-flight one.

Optional Feature:
Macro WB_FORWARD_EN.
- Defined: lkhit=1 when any valid entry (in-flight included) matches lkadr.
  - lkdata/lkbyteen come from the non-in-flight match if present. Bytes that match absent are filled from the in-flight match.
  - lkbyteen is the OR of both matches' byteen.
  - Purely combinational, no added latency.
- Undefined: lkhit, lkdata and lkbyteen are tied to 0; lkadr is unused.

Decomposition:
- Package wb_pkg: function clog2; entry struct typedef (valid, adr, data, byteen); drain state enum (IDLE, BUSY).
- One sub-module, wb_entry: a single storage entry with byte-lane merge logic. It has load, merge and clear controls and exposes its contents for the match and forwarding comparators.

Test Plan:
1. Reset, then write adr=0x00AD data=0xBEADBEEF byteen=4'hF. Expect done=1; next cycle memen=1, memadr=0x00AD, memdata=0xBEADBEEF. memdone pulse gives memen=0, empty=1.
2. Hold memdone=0, issue 4 writes to adr 1..4. Expect full=1, count=4. A 5th write to adr 5 gives done=0. Pulse memdone gives count=3, then the 5th write is accepted.
3. Merge: with memdone stalled on adr 1, write adr=2 data=0x000000AA byteen=4'h1, then adr=2 data=0x0000BB00 byteen=4'h2. Expect count=2; adr 2 drains as data=0x0000BBAA, byteen=4'h3.
4. No merge into in-flight: while adr=7 is in-flight (memen=1, memdone=0), write adr=7. Expect a new entry, count=2, and two separate memory writes.
5. WB_FORWARD_EN: buffer holds adr=9 data=0x11223344 byteen=4'hC. Lookup lkadr=9 gives lkhit=1, lkbyteen=4'hC, lkdata[31:16]=0x1122. lkadr=10 gives lkhit=0.
6. Assert reset mid-BUSY with 3 entries pending. Expect memen=0, count=0, empty=1 immediately; after release, no writes are issued.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the coalescing write buffer.
// The WB_FORWARD_EN macro, handled in the top module, enables read-lookup forwarding.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADR_W  = 27;
  localparam int WB_DATA_W = 32;
  localparam int WB_BE_W   = WB_DATA_W / 8;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [WB_ADR_W-1:0]  adr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_BE_W-1:0]   byteen;
  } entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

endpackage

// File: rtl/write_buffer_coalescing_if.sv
// Bus bundle of the write buffer: cache write port, memory drain port, lookup port, status.
// The slave modport is the buffer's view; master is the surrounding system.
interface write_buffer_coalescing_if
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADR_W  = WB_ADR_W,
  parameter int DATA_W = WB_DATA_W
) ();

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;
  logic [BE_W-1:0]   byteen;
  logic              en;
  logic              done;
  logic [ADR_W-1:0]  memadr;
  logic [DATA_W-1:0] memdata;
  logic [BE_W-1:0]   membyteen;
  logic              memen;
  logic              memdone;
  logic [ADR_W-1:0]  lkadr;
  logic              lkhit;
  logic [DATA_W-1:0] lkdata;
  logic [BE_W-1:0]   lkbyteen;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport slave (
    input  adr, data, byteen, en, memdone, lkadr,
    output done, memadr, memdata, membyteen, memen,
           lkhit, lkdata, lkbyteen, count, empty, full
  );

  modport master (
    output adr, data, byteen, en, memdone, lkadr,
    input  done, memadr, memdata, membyteen, memen,
           lkhit, lkdata, lkbyteen, count, empty, full
  );

endinterface

// File: rtl/write_buffer_coalescing_entry.sv
// One write-buffer slot with byte-lane merge. Exposes both current and next-state
// contents so the drain logic can load a value being merged at the same edge.
module wb_entry
  import wb_pkg::*;
#(
  parameter int ADR_W  = WB_ADR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              merge_i,
  input  logic              clear_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   byteen_i,
  output logic              valid_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [BE_W-1:0]   byteen_o,
  output logic              valid_d_o,
  output logic [ADR_W-1:0]  adr_d_o,
  output logic [DATA_W-1:0] data_d_o,
  output logic [BE_W-1:0]   byteen_d_o
);

  logic              valid_q, valid_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BE_W-1:0]   byteen_q, byteen_d;

  // Next-state: clear, allocate, or merge enabled byte lanes.
  always_comb begin
    valid_d  = valid_q;
    adr_d    = adr_q;
    data_d   = data_q;
    byteen_d = byteen_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d  = 1'b1;
      adr_d    = adr_i;
      data_d   = data_i;
      byteen_d = byteen_i;
    end else if (merge_i) begin
      for (int b = 0; b < BE_W; b++) begin
        data_d[8*b +: 8] = byteen_i[b] ? data_i[8*b +: 8] : data_q[8*b +: 8];
      end
      byteen_d = byteen_q | byteen_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      adr_q    <= {ADR_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      byteen_q <= {BE_W{1'b0}};
    end else begin
      valid_q  <= valid_d;
      adr_q    <= adr_d;
      data_q   <= data_d;
      byteen_q <= byteen_d;
    end
  end

  assign valid_o    = valid_q;
  assign adr_o      = adr_q;
  assign data_o     = data_q;
  assign byteen_o   = byteen_q;
  assign valid_d_o  = valid_d;
  assign adr_d_o    = adr_d;
  assign data_d_o   = data_d;
  assign byteen_d_o = byteen_d;

endmodule

// File: rtl/write_buffer_coalescing.sv
// Coalescing write buffer: FIFO of word writes, merged by address, drained oldest-first.
// Define WB_FORWARD_EN to enable byte forwarding on the lookup port.
module write_buffer_coalescing
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADR_W  = WB_ADR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input logic                      ph1,
  input logic                      ph2,
  input logic                      reset,
  write_buffer_coalescing_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
  logic [ADR_W-1:0]  ent_adr_q [DEPTH];
  logic [ADR_W-1:0]  ent_adr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [BE_W-1:0]   ent_be_q [DEPTH];
  logic [BE_W-1:0]   ent_be_d [DEPTH];
  logic [DEPTH-1:0]  ent_load_s, ent_merge_s, ent_clear_s, match_s, inflight_s;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nxt_s;
  logic [CNT_W-1:0]  count_q, count_d;
  drain_state_t      state_q, state_d;
  logic              memen_q, memen_d;
  logic [ADR_W-1:0]  memadr_q, memadr_d;
  logic [DATA_W-1:0] memdata_q, memdata_d;
  logic [BE_W-1:0]   membyteen_q, membyteen_d;

  logic full_s, be_zero_s, merge_hit_s, done_s, accept_s, alloc_s, retire_s;
  logic unused_ph2;

  assign unused_ph2 = ph2;

  assign full_s      = (count_q == CNT_W'(DEPTH));
  assign be_zero_s   = (bus.byteen == {BE_W{1'b0}});
  assign merge_hit_s = bus.en & (|match_s);
  assign done_s      = be_zero_s | merge_hit_s | ~full_s;
  assign accept_s    = bus.en & done_s & ~be_zero_s;
  assign alloc_s     = accept_s & ~merge_hit_s;
  assign retire_s    = (state_q == BUSY) & bus.memdone;
  assign head_nxt_s  = head_q + PTR_W'(1);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    // The in-flight head is excluded from merging so memory sees a stable value.
    assign inflight_s[i]  = memen_q & (head_q == PTR_W'(i));
    assign match_s[i]     = ent_valid_q[i] & (ent_adr_q[i] == bus.adr) & ~inflight_s[i];
    assign ent_load_s[i]  = alloc_s & (tail_q == PTR_W'(i));
    assign ent_merge_s[i] = accept_s & match_s[i];
    assign ent_clear_s[i] = retire_s & (head_q == PTR_W'(i));

    wb_entry #(
      .ADR_W  (ADR_W),
      .DATA_W (DATA_W),
      .BE_W   (BE_W)
    ) u_entry (
      .clk_i      (ph1),
      .rst_n_i    (reset),
      .load_i     (ent_load_s[i]),
      .merge_i    (ent_merge_s[i]),
      .clear_i    (ent_clear_s[i]),
      .adr_i      (bus.adr),
      .data_i     (bus.data),
      .byteen_i   (bus.byteen),
      .valid_o    (ent_valid_q[i]),
      .adr_o      (ent_adr_q[i]),
      .data_o     (ent_data_q[i]),
      .byteen_o   (ent_be_q[i]),
      .valid_d_o  (ent_valid_d[i]),
      .adr_d_o    (ent_adr_d[i]),
      .data_d_o   (ent_data_d[i]),
      .byteen_d_o (ent_be_d[i])
    );
  end

  // Drain FSM next-state; loads from entry next-state so same-edge writes are seen.
  always_comb begin
    state_d     = state_q;
    memen_d     = memen_q;
    memadr_d    = memadr_q;
    memdata_d   = memdata_q;
    membyteen_d = membyteen_q;
    head_d      = head_q;
    case (state_q)
      IDLE: begin
        if (ent_valid_d[head_q]) begin
          state_d     = BUSY;
          memen_d     = 1'b1;
          memadr_d    = ent_adr_d[head_q];
          memdata_d   = ent_data_d[head_q];
          membyteen_d = ent_be_d[head_q];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (retire_s) begin
          head_d = head_nxt_s;
          if (ent_valid_d[head_nxt_s]) begin
            memadr_d    = ent_adr_d[head_nxt_s];
            memdata_d   = ent_data_d[head_nxt_s];
            membyteen_d = ent_be_d[head_nxt_s];
          end else begin
            state_d = IDLE;
            memen_d = 1'b0;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        memen_d = 1'b0;
      end
    endcase
  end

  assign tail_d  = tail_q + PTR_W'(alloc_s);
  assign count_d = count_q + CNT_W'(alloc_s) - CNT_W'(retire_s);

  // Pointers, occupancy and registered memory-port outputs.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      memen_q     <= 1'b0;
      memadr_q    <= {ADR_W{1'b0}};
      memdata_q   <= {DATA_W{1'b0}};
      membyteen_q <= {BE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      memen_q     <= memen_d;
      memadr_q    <= memadr_d;
      memdata_q   <= memdata_d;
      membyteen_q <= membyteen_d;
    end
  end

  assign bus.done      = done_s;
  assign bus.memen     = memen_q;
  assign bus.memadr    = memadr_q;
  assign bus.memdata   = memdata_q;
  assign bus.membyteen = membyteen_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == {CNT_W{1'b0}});
  assign bus.full      = full_s;

`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0]  lk_match_s, lk_nf_s;
  logic [DATA_W-1:0] lk_nf_data_s, lk_data_s;
  logic [BE_W-1:0]   lk_nf_be_s, lk_be_s;
  logic              lk_if_hit_s;

  // Forwarding: pending (non-in-flight) bytes take priority over the in-flight copy.
  always_comb begin
    lk_match_s   = {DEPTH{1'b0}};
    lk_nf_data_s = {DATA_W{1'b0}};
    lk_nf_be_s   = {BE_W{1'b0}};
    lk_data_s    = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lk_match_s[i] = ent_valid_q[i] & (ent_adr_q[i] == bus.lkadr);
    end
    lk_nf_s     = lk_match_s & ~inflight_s;
    lk_if_hit_s = |(lk_match_s & inflight_s);
    for (int i = 0; i < DEPTH; i++) begin
      lk_nf_data_s = lk_nf_data_s | (ent_data_q[i] & {DATA_W{lk_nf_s[i]}});
      lk_nf_be_s   = lk_nf_be_s | (ent_be_q[i] & {BE_W{lk_nf_s[i]}});
    end
    for (int b = 0; b < BE_W; b++) begin
      lk_data_s[8*b +: 8] = lk_nf_be_s[b] ? lk_nf_data_s[8*b +: 8] :
                            (lk_if_hit_s ? ent_data_q[head_q][8*b +: 8] : 8'h00);
    end
    lk_be_s = lk_nf_be_s | (lk_if_hit_s ? ent_be_q[head_q] : {BE_W{1'b0}});
  end

  assign bus.lkhit    = |lk_match_s;
  assign bus.lkdata   = lk_data_s;
  assign bus.lkbyteen = lk_be_s;
`else
  logic unused_lkadr;

  assign unused_lkadr = ^bus.lkadr;
  assign bus.lkhit    = 1'b0;
  assign bus.lkdata   = {DATA_W{1'b0}};
  assign bus.lkbyteen = {BE_W{1'b0}};
`endif

endmodule

// File: tb/tb_write_buffer_coalescing.sv
// Directed plus random bench for write_buffer_coalescing against a queue-based model.
module tb_write_buffer_coalescing;
  import wb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADR_W  = 27;
  localparam int DATA_W = 32;

  logic ph1   = 1'b0;
  logic ph2   = 1'b1;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 ph1 = ~ph1;
  always #5 ph2 = ~ph2;

  write_buffer_coalescing_if #(.DEPTH(DEPTH), .ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  write_buffer_coalescing #(.DEPTH(DEPTH), .ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .ph1   (ph1),
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: ordered list of pending writes; element 0 is in flight while m_memen.
  entry_t      m_q[$];
  logic        m_memen;
  logic [26:0] m_memadr;
  logic [31:0] m_memdata;
  logic [3:0]  m_membe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_memen   = 1'b0;
    m_memadr  = 27'd0;
    m_memdata = 32'd0;
    m_membe   = 4'd0;
  endtask

  function automatic int merge_idx();
    int r;
    r = -1;
    foreach (m_q[i]) begin
      if (m_q[i].adr == bus.adr && !(i == 0 && m_memen)) r = i;
    end
    return r;
  endfunction

  task automatic exp_lookup(output logic h, output logic [31:0] d, output logic [3:0] be);
    logic        nf, ifh;
    logic [31:0] nd, idt;
    logic [3:0]  nb, ib;
    h = 1'b0; d = 32'd0; be = 4'd0;
    nf = 1'b0; ifh = 1'b0; nd = 32'd0; idt = 32'd0; nb = 4'd0; ib = 4'd0;
`ifdef WB_FORWARD_EN
    foreach (m_q[i]) begin
      if (m_q[i].adr == bus.lkadr) begin
        if (i == 0 && m_memen) begin
          ifh = 1'b1; idt = m_q[i].data; ib = m_q[i].byteen;
        end else begin
          nf = 1'b1; nd = m_q[i].data; nb = m_q[i].byteen;
        end
      end
    end
    h  = nf | ifh;
    be = nb | ib;
    for (int b = 0; b < 4; b++) begin
      d[8*b +: 8] = nb[b] ? nd[8*b +: 8] : (ifh ? idt[8*b +: 8] : 8'h00);
    end
`endif
  endtask

  task automatic check_all();
    logic        eh, ed;
    logic [31:0] edat;
    logic [3:0]  ebe;
    int          mi;
    mi = merge_idx();
    ed = (bus.byteen == 4'd0) || (bus.en && mi >= 0) || (m_q.size() < DEPTH);
    exp_lookup(eh, edat, ebe);
    chk("count", 64'(bus.count), 64'(m_q.size()));
    chk("empty", 64'(bus.empty), 64'(m_q.size() == 0));
    chk("full", 64'(bus.full), 64'(m_q.size() == DEPTH));
    chk("done", 64'(bus.done), 64'(ed));
    chk("memen", 64'(bus.memen), 64'(m_memen));
    chk("memadr", 64'(bus.memadr), 64'(m_memadr));
    chk("memdata", 64'(bus.memdata), 64'(m_memdata));
    chk("membyteen", 64'(bus.membyteen), 64'(m_membe));
    chk("lkhit", 64'(bus.lkhit), 64'(eh));
    chk("lkdata", 64'(bus.lkdata), 64'(edat));
    chk("lkbyteen", 64'(bus.lkbyteen), 64'(ebe));
  endtask

  task automatic model_step();
    entry_t e;
    int     mi;
    if (bus.en && bus.byteen != 4'd0) begin
      mi = merge_idx();
      if (mi >= 0) begin
        e = m_q[mi];
        for (int b = 0; b < 4; b++) begin
          if (bus.byteen[b]) e.data[8*b +: 8] = bus.data[8*b +: 8];
        end
        e.byteen = e.byteen | bus.byteen;
        m_q[mi]  = e;
      end else if (m_q.size() < DEPTH) begin
        e.valid = 1'b1; e.adr = bus.adr; e.data = bus.data; e.byteen = bus.byteen;
        m_q.push_back(e);
      end
    end
    if (!m_memen) begin
      if (m_q.size() > 0) begin
        m_memen = 1'b1; m_memadr = m_q[0].adr; m_memdata = m_q[0].data; m_membe = m_q[0].byteen;
      end
    end else if (bus.memdone) begin
      void'(m_q.pop_front());
      if (m_q.size() > 0) begin
        m_memadr = m_q[0].adr; m_memdata = m_q[0].data; m_membe = m_q[0].byteen;
      end else begin
        m_memen = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge ph1);
    check_all();
    model_step();
    @(posedge ph1);
    #1;
  endtask

  task automatic wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.en = 1'b1; bus.adr = a; bus.data = d; bus.byteen = be;
    tick();
    bus.en = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.adr = 27'd0; bus.data = 32'd0; bus.byteen = 4'd0;
    bus.memdone = 1'b0; bus.lkadr = 27'd0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_memen", 64'(bus.memen), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd1);
    repeat (2) @(negedge ph1);
    reset = 1'b1;
    @(posedge ph1); #1;

    // 1: single write, one-cycle latency to memen, then drain
    wr(27'h00AD, 32'hBEADBEEF, 4'hF);
    chk("p1_memen", 64'(bus.memen), 64'd1);
    chk("p1_memadr", 64'(bus.memadr), 64'h00AD);
    chk("p1_memdata", 64'(bus.memdata), 64'hBEADBEEF);
    bus.memdone = 1'b1; tick(); bus.memdone = 1'b0;
    chk("p1_idle", 64'(bus.memen), 64'd0);
    chk("p1_empty", 64'(bus.empty), 64'd1);

    // 2: fill, refuse when full even alongside a retire, then accept
    for (int i = 1; i <= 4; i++) wr(27'(i), 32'(i * 32'h01010101), 4'hF);
    chk("p2_full", 64'(bus.full), 64'd1);
    chk("p2_count", 64'(bus.count), 64'd4);
    bus.en = 1'b1; bus.adr = 27'd5; bus.data = 32'h55555555; bus.byteen = 4'hF;
    #1 chk("p2_done_full", 64'(bus.done), 64'd0);
    tick();
    bus.memdone = 1'b1; tick(); bus.memdone = 1'b0;
    chk("p2_count3", 64'(bus.count), 64'd3);
    tick(); bus.en = 1'b0;
    chk("p2_count4", 64'(bus.count), 64'd4);
    bus.memdone = 1'b1; repeat (4) tick(); bus.memdone = 1'b0;
    chk("p2_drained", 64'(bus.empty), 64'd1);

    // 3: merge two partial writes behind a stalled entry
    wr(27'd1, 32'h11111111, 4'hF);
    wr(27'd2, 32'h000000AA, 4'h1);
    wr(27'd2, 32'h0000BB00, 4'h2);
    chk("p3_count", 64'(bus.count), 64'd2);
    bus.memdone = 1'b1; tick();
    chk("p3_memadr", 64'(bus.memadr), 64'd2);
    chk("p3_memdata", 64'(bus.memdata), 64'h0000BBAA);
    chk("p3_membe", 64'(bus.membyteen), 64'h3);
    tick(); bus.memdone = 1'b0;

    // 4: same address as in-flight allocates a new entry
    wr(27'd7, 32'hA0A0A0A0, 4'hF);
    wr(27'd7, 32'hB0B0B0B0, 4'hF);
    chk("p4_count", 64'(bus.count), 64'd2);
    bus.memdone = 1'b1; tick();
    chk("p4_second", 64'(bus.memdata), 64'hB0B0B0B0);
    tick(); bus.memdone = 1'b0;
    chk("p4_idle", 64'(bus.memen), 64'd0);

    // 5: lookup forwarding
    wr(27'd8, 32'h88888888, 4'hF);
    wr(27'd9, 32'h11223344, 4'hC);
    bus.lkadr = 27'd9;
    #1;
`ifdef WB_FORWARD_EN
    chk("p5_hit", 64'(bus.lkhit), 64'd1);
    chk("p5_be", 64'(bus.lkbyteen), 64'hC);
    chk("p5_data", 64'(bus.lkdata[31:16]), 64'h1122);
`else
    chk("p5_hit_off", 64'(bus.lkhit), 64'd0);
`endif
    bus.lkadr = 27'd10;
    #1 chk("p5_miss", 64'(bus.lkhit), 64'd0);

    // 6: asynchronous reset while busy drops everything
    wr(27'd10, 32'hAAAA0000, 4'hF);
    wr(27'd11, 32'hBBBB0000, 4'hF);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("p6_memen", 64'(bus.memen), 64'd0);
    chk("p6_count", 64'(bus.count), 64'd0);
    chk("p6_empty", 64'(bus.empty), 64'd1);
    @(negedge ph1) reset = 1'b1;
    @(posedge ph1); #1;
    bus.memdone = 1'b1; repeat (5) tick(); bus.memdone = 1'b0;

    // Random traffic over a small address window to provoke merges
    for (int n = 0; n < 600; n++) begin
      bus.en      = ($urandom_range(0, 3) != 0);
      bus.adr     = 27'($urandom_range(0, 5));
      bus.data    = $urandom;
      bus.byteen  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.memdone = ($urandom_range(0, 2) == 0);
      bus.lkadr   = 27'($urandom_range(0, 6));
      tick();
    end
    bus.en = 1'b0; bus.memdone = 1'b1;
    repeat (6) tick();
    chk("final_empty", 64'(bus.empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
